// File: rtl/mem_access.sv
// mem_access: memory-access stage of the multi-cycle core.
// Runs at most one data-bus transaction per MEM visit, steers store bytes
// onto the proper lanes and sign/zero-extends loaded bytes and halves.
// instr bit layout: [0]=lb [1]=lh [2]=lw [3]=lbu [4]=lhu [5]=sb [6]=sh [7]=sw
module mem_access #(
  parameter int          ADDR_W    = 32,
  parameter logic [2:0]  MEM_STATE = 3'd3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        state,
  input  logic [7:0]        instr,
  input  logic [31:0]       exec_result,
  input  logic [31:0]       store_v,
  input  logic              mem_read_enabled,
  input  logic              mem_write_enabled,
  input  logic              reg_write_enabled_in,
  input  logic [4:0]        reg_write_dest_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       result,
  output logic              reg_write_enabled,
  output logic [4:0]        reg_write_dest,
  output logic              completed,
  output logic              misaligned
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} fsm_t;

  fsm_t       fsm;
  logic [1:0] off_reg;
  logic [4:0] ld_type_reg;   // {lhu, lbu, lw, lh, lb}
  logic       is_store_reg;
  logic       rwe_reg;
  logic [4:0] dest_reg;

  logic        is_byte, is_half, is_word, is_mem, misalign_c;
  logic [31:0] wdata_c;
  logic [3:0]  wstrb_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] load_c;

  assign is_byte = instr[0] | instr[3] | instr[5];
  assign is_half = instr[1] | instr[4] | instr[6];
  assign is_word = instr[2] | instr[7];
  assign is_mem  = mem_read_enabled | mem_write_enabled;

  // Alignment check and store lane steering for the access about to be issued
  always_comb begin
    misalign_c = (is_half & exec_result[0]) | (is_word & (exec_result[1:0] != 2'b00));
    wdata_c    = 32'h0;
    wstrb_c    = 4'h0;
    if (mem_write_enabled) begin
      if (is_byte) begin
        wdata_c = {4{store_v[7:0]}};
        wstrb_c = 4'b0001 << exec_result[1:0];
      end else if (is_half) begin
        wdata_c = {2{store_v[15:0]}};
        wstrb_c = exec_result[1] ? 4'b1100 : 4'b0011;
      end else if (is_word) begin
        wdata_c = store_v;
        wstrb_c = 4'b1111;
      end
    end
  end

  // Extract and extend the loaded byte/half at the latched offset
  always_comb begin
    case (off_reg)
      2'd0:    byte_c = mem_rdata[7:0];
      2'd1:    byte_c = mem_rdata[15:8];
      2'd2:    byte_c = mem_rdata[23:16];
      default: byte_c = mem_rdata[31:24];
    endcase
    half_c = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_c = mem_rdata;
    if (ld_type_reg[0])      load_c = {{24{byte_c[7]}}, byte_c};
    else if (ld_type_reg[1]) load_c = {{16{half_c[15]}}, half_c};
    else if (ld_type_reg[3]) load_c = {24'h0, byte_c};
    else if (ld_type_reg[4]) load_c = {16'h0, half_c};
  end

  // Stage FSM with registered bus and write-back outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm               <= S_IDLE;
      off_reg           <= 2'b00;
      ld_type_reg       <= 5'h0;
      is_store_reg      <= 1'b0;
      rwe_reg           <= 1'b0;
      dest_reg          <= 5'h0;
      mem_req           <= 1'b0;
      mem_we            <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= 32'h0;
      mem_wstrb         <= 4'h0;
      result            <= 32'h0;
      reg_write_enabled <= 1'b0;
      reg_write_dest    <= 5'h0;
      completed         <= 1'b0;
      misaligned        <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (state == MEM_STATE) begin
            if (!is_mem) begin
              result            <= exec_result;
              reg_write_enabled <= reg_write_enabled_in;
              reg_write_dest    <= reg_write_dest_in;
              misaligned        <= 1'b0;
              completed         <= 1'b1;
              fsm               <= S_DONE;
            end else if (misalign_c) begin
              // Suppressed access: report it and skip write-back
              misaligned        <= 1'b1;
              reg_write_enabled <= 1'b0;
              reg_write_dest    <= reg_write_dest_in;
              completed         <= 1'b1;
              fsm               <= S_DONE;
            end else begin
              misaligned   <= 1'b0;
              mem_req      <= 1'b1;
              mem_we       <= mem_write_enabled;
              mem_addr     <= ADDR_W'({exec_result[31:2], 2'b00});
              mem_wdata    <= wdata_c;
              mem_wstrb    <= wstrb_c;
              off_reg      <= exec_result[1:0];
              ld_type_reg  <= {instr[4], instr[3], instr[2], instr[1], instr[0]};
              is_store_reg <= mem_write_enabled;
              rwe_reg      <= reg_write_enabled_in;
              dest_reg     <= reg_write_dest_in;
              fsm          <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Bus outputs stay frozen until the slave accepts, whatever state does
          if (mem_ready) begin
            mem_req        <= 1'b0;
            completed      <= 1'b1;
            reg_write_dest <= dest_reg;
            fsm            <= S_DONE;
            if (is_store_reg) begin
              reg_write_enabled <= 1'b0;
            end else begin
              result            <= load_c;
              reg_write_enabled <= rwe_reg;
            end
          end
        end
        default: begin
          completed <= 1'b0;
          if (state != MEM_STATE) fsm <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access: one task per scenario, inline checks.
module tb_mem_access;

  localparam logic [2:0] MEM = 3'd3;
  localparam logic [7:0] I_LB = 8'h01, I_LH = 8'h02, I_LW = 8'h04, I_LBU = 8'h08,
                         I_LHU = 8'h10, I_SB = 8'h20, I_SH = 8'h40, I_SW = 8'h80;

  logic        clk, rst;
  logic [2:0]  state;
  logic [7:0]  instr;
  logic [31:0] exec_result, store_v;
  logic        mem_read_enabled, mem_write_enabled, reg_write_enabled_in;
  logic [4:0]  reg_write_dest_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] result;
  logic        reg_write_enabled;
  logic [4:0]  reg_write_dest;
  logic        completed, misaligned;

  int checks = 0;
  int failures = 0;

  mem_access #(.ADDR_W(32), .MEM_STATE(MEM)) dut (
    .clk(clk), .rst(rst), .state(state), .instr(instr),
    .exec_result(exec_result), .store_v(store_v),
    .mem_read_enabled(mem_read_enabled), .mem_write_enabled(mem_write_enabled),
    .reg_write_enabled_in(reg_write_enabled_in), .reg_write_dest_in(reg_write_dest_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .result(result), .reg_write_enabled(reg_write_enabled),
    .reg_write_dest(reg_write_dest), .completed(completed), .misaligned(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an instruction to the stage with state = MEM (called at a negedge)
  task automatic drive(input logic [7:0] ins, input logic [31:0] ex, input logic [31:0] sv,
                       input logic rd, input logic wr, input logic rwe, input logic [4:0] dst);
    state = MEM; instr = ins; exec_result = ex; store_v = sv;
    mem_read_enabled = rd; mem_write_enabled = wr;
    reg_write_enabled_in = rwe; reg_write_dest_in = dst;
  endtask

  // Leave MEM and let the FSM fall back to IDLE
  task automatic leave();
    state = 3'd0; mem_ready = 1'b0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; state = 3'd0; instr = 8'h0; exec_result = 0; store_v = 0;
    mem_read_enabled = 0; mem_write_enabled = 0; reg_write_enabled_in = 0;
    reg_write_dest_in = 0; mem_ready = 0; mem_rdata = 0;
    @(negedge clk); @(negedge clk);
    checks++; if ({mem_req, completed, misaligned, reg_write_enabled} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {mem_req, completed, misaligned, reg_write_enabled}); end
    checks++; if (result !== 32'h0 || reg_write_dest !== 5'h0) begin failures++; $display("FAIL reset_result got=%h/%h exp=0/0", result, reg_write_dest); end
    rst = 1'b0;
    @(negedge clk);
    $display("reset: checked idle outputs");
  endtask

  task automatic test_alu();
    drive(8'h0, 32'h1234, 32'h0, 0, 0, 1, 5'd5);
    @(negedge clk); // cycle T+1
    checks++; if (completed !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL alu_completed got=%b req=%b exp=1 req=0", completed, mem_req); end
    checks++; if (result !== 32'h1234 || reg_write_enabled !== 1'b1 || reg_write_dest !== 5'd5) begin failures++; $display("FAIL alu_result got=%h/%b/%0d exp=1234/1/5", result, reg_write_enabled, reg_write_dest); end
    @(negedge clk);
    checks++; if (completed !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL alu_pulse got=%b req=%b exp=0 req=0", completed, mem_req); end
    leave();
    $display("alu: result=%h", result);
  endtask

  task automatic test_load_byte(input logic [7:0] ins, input logic [31:0] exp_res, input string nm);
    drive(ins, 32'h103, 32'h0, 1, 0, 1, 5'd7);
    @(negedge clk); // T+1: request visible
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || mem_wstrb !== 4'h0 || completed !== 1'b0) begin failures++; $display("FAIL %s_req got=req%b we%b addr%h strb%h c%b exp=req1 we0 addr100 strb0 c0", nm, mem_req, mem_we, mem_addr, mem_wstrb, completed); end
    mem_ready = 1'b1; mem_rdata = 32'h80FF_0000;
    @(negedge clk); // T+2
    mem_ready = 1'b0;
    checks++; if (completed !== 1'b1 || result !== exp_res || reg_write_enabled !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL %s_data got=c%b res%h rwe%b req%b exp=c1 res%h rwe1 req0", nm, completed, result, reg_write_enabled, mem_req, exp_res); end
    leave();
    $display("%s: addr=100 result=%h", nm, result);
  endtask

  task automatic test_sh_waits();
    drive(I_SH, 32'h202, 32'hDEAD_BEEF, 0, 1, 1, 5'd9);
    @(negedge clk); // T+1
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hBEEF_BEEF || mem_wstrb !== 4'b1100) begin failures++; $display("FAIL sh_req got=req%b we%b addr%h wd%h strb%b exp=req1 we1 addr200 wdBEEFBEEF strb1100", mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (completed !== 1'b0 || mem_req !== 1'b1 || mem_wdata !== 32'hBEEF_BEEF || mem_wstrb !== 4'b1100) begin failures++; $display("FAIL sh_wait%0d got=c%b req%b wd%h strb%b exp=c0 req1 wdBEEFBEEF strb1100", i, completed, mem_req, mem_wdata, mem_wstrb); end
    end
    mem_ready = 1'b1;
    @(negedge clk); // T+5
    mem_ready = 1'b0;
    checks++; if (completed !== 1'b1 || reg_write_enabled !== 1'b0 || result !== 32'h80) begin failures++; $display("FAIL sh_done got=c%b rwe%b res%h exp=c1 rwe0 res00000080", completed, reg_write_enabled, result); end
    leave();
    $display("sh: wdata=BEEFBEEF wstrb=1100 done at T+5");
  endtask

  task automatic test_sb_lane();
    drive(I_SB, 32'h501, 32'h0000_00AB, 0, 1, 0, 5'd0);
    @(negedge clk);
    checks++; if (mem_addr !== 32'h500 || mem_wdata !== 32'hABAB_ABAB || mem_wstrb !== 4'b0010) begin failures++; $display("FAIL sb_lane got=addr%h wd%h strb%b exp=addr500 wdABABABAB strb0010", mem_addr, mem_wdata, mem_wstrb); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    leave();
    $display("sb: wdata=%h wstrb=%b", mem_wdata, mem_wstrb);
  endtask

  task automatic test_misaligned();
    drive(I_LW, 32'h101, 32'h0, 1, 0, 1, 5'd3);
    @(negedge clk); // T+1
    checks++; if (mem_req !== 1'b0 || misaligned !== 1'b1 || reg_write_enabled !== 1'b0 || completed !== 1'b1) begin failures++; $display("FAIL lw_misaligned got=req%b mis%b rwe%b c%b exp=req0 mis1 rwe0 c1", mem_req, misaligned, reg_write_enabled, completed); end
    drive(I_LH, 32'h301, 32'h0, 1, 0, 1, 5'd3);
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || misaligned !== 1'b1 || completed !== 1'b0) begin failures++; $display("FAIL mis_hold got=req%b mis%b c%b exp=req0 mis1 c0", mem_req, misaligned, completed); end
    leave();
    $display("misaligned lw: suppressed");
  endtask

  task automatic test_back_to_back();
    int reqs, dones;
    reqs = 0; dones = 0;
    mem_ready = 1'b1;
    drive(I_SW, 32'h400, 32'h1122_3344, 0, 1, 0, 5'd0);
    @(negedge clk);
    checks++; if (misaligned !== 1'b0 || mem_wdata !== 32'h1122_3344 || mem_wstrb !== 4'b1111) begin failures++; $display("FAIL sw_req got=mis%b wd%h strb%b exp=mis0 wd11223344 strb1111", misaligned, mem_wdata, mem_wstrb); end
    if (mem_req === 1'b1) reqs++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1) reqs++;
      if (completed === 1'b1) dones++;
    end
    checks++; if (reqs !== 1 || dones !== 1) begin failures++; $display("FAIL one_per_visit got=reqs%0d dones%0d exp=1/1", reqs, dones); end
    state = 3'd0;
    @(negedge clk);
    state = MEM;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin failures++; $display("FAIL reenter_req got=req%b addr%h exp=req1 addr400", mem_req, mem_addr); end
    @(negedge clk);
    checks++; if (completed !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL reenter_done got=c%b req%b exp=c1 req0", completed, mem_req); end
    leave();
    $display("back_to_back: reqs=%0d dones=%0d", reqs, dones);
  endtask

  task automatic test_reset_in_wait();
    drive(I_LHU, 32'h300, 32'h0, 1, 0, 1, 5'd12);
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL lhu_req got=%b exp=1", mem_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || completed !== 1'b0 || result !== 32'h0) begin failures++; $display("FAIL async_reset got=req%b c%b res%h exp=req0 c0 res0", mem_req, completed, result); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); // IDLE sees MEM again: fresh request
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin failures++; $display("FAIL fresh_req got=req%b addr%h exp=req1 addr300", mem_req, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 32'h1234_8001;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++; if (completed !== 1'b1 || result !== 32'h0000_8001 || reg_write_dest !== 5'd12) begin failures++; $display("FAIL lhu_data got=c%b res%h dst%0d exp=c1 res00008001 dst12", completed, result, reg_write_dest); end
    leave();
    drive(I_LH, 32'h302, 32'h0, 1, 0, 1, 5'd13);
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'h8001_0000;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++; if (completed !== 1'b1 || result !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_sext got=c%b res%h exp=c1 resFFFF8001", completed, result); end
    leave();
    $display("reset_in_wait: fresh lhu result=00008001");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_byte(I_LB, 32'hFFFF_FF80, "lb");
    test_load_byte(I_LBU, 32'h0000_0080, "lbu");
    test_sh_waits();
    test_misaligned();
    test_back_to_back();
    test_sb_lane();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
